// File: rtl/axis_frame_buf_v1.sv
// Frame capture buffer: stores a requested frame from a non-stallable stream into a FIFO
// and replays it as an AXI-Stream master with tready/tlast for the DMA.
module axis_frame_buf_v1 #(
    parameter int unsigned B       = 256,
    parameter int unsigned FIFO_AW = 4,
    parameter int unsigned LEN_W   = 16
) (
    input  logic             aclk,
    input  logic             aresetn,
    input  logic             s_axis_tvalid,
    input  logic [B-1:0]     s_axis_tdata,
    output logic             m_axis_tvalid,
    input  logic             m_axis_tready,
    output logic [B-1:0]     m_axis_tdata,
    output logic             m_axis_tlast,
    input  logic             start_i,
    input  logic [LEN_W-1:0] len_i,
    output logic             busy_o,
    output logic             ovf_o
);

    localparam int unsigned DEPTH = 2 ** FIFO_AW;
    localparam int unsigned OCC_W = FIFO_AW + 1;

    typedef enum logic {
        IDLE,
        CAPTURE
    } state_t;

    state_t             state;
    logic [LEN_W-1:0]   len_q;
    logic [LEN_W-1:0]   cnt_q;
    logic [FIFO_AW-1:0] wr_ptr;
    logic [FIFO_AW-1:0] rd_ptr;
    logic [OCC_W-1:0]   occ;
    logic [B:0]         mem [DEPTH];
    logic [B:0]         head;

    logic rd_en;
    logic wr_en;
    logic is_last;
    logic has_room;
    logic word_in;

    // Write decision: one slot is held back so the last word of a frame always fits.
    always_comb begin
        word_in  = (state == CAPTURE) && s_axis_tvalid;
        rd_en    = (occ != '0) && m_axis_tready;
        is_last  = (cnt_q == (len_q - LEN_W'(1)));
        has_room = (occ < OCC_W'(DEPTH - 1));
        wr_en    = word_in && (has_room || (is_last && ((occ != OCC_W'(DEPTH)) || rd_en)));
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state  <= IDLE;
            len_q  <= '0;
            cnt_q  <= '0;
            busy_o <= 1'b0;
            ovf_o  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start_i && (len_i != '0)) begin
                        state  <= CAPTURE;
                        len_q  <= len_i;
                        cnt_q  <= '0;
                        ovf_o  <= 1'b0;
                        busy_o <= 1'b1;
                    end
                end
                CAPTURE: begin
                    if (s_axis_tvalid) begin
                        cnt_q <= cnt_q + LEN_W'(1);
                        if (!wr_en) begin
                            ovf_o <= 1'b1;
                        end
                        if (is_last) begin
                            state  <= IDLE;
                            busy_o <= 1'b0;
                        end
                    end
                end
                default: begin
                    state  <= IDLE;
                    busy_o <= 1'b0;
                end
            endcase
        end
    end

    // FIFO pointers and occupancy; a simultaneous read and write leaves occupancy unchanged.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + FIFO_AW'(1);
            end
            if (rd_en) begin
                rd_ptr <= rd_ptr + FIFO_AW'(1);
            end
            case ({wr_en, rd_en})
                2'b10:   occ <= occ + OCC_W'(1);
                2'b01:   occ <= occ - OCC_W'(1);
                default: occ <= occ;
            endcase
        end
    end

    always_ff @(posedge aclk) begin
        if (wr_en) begin
            mem[wr_ptr] <= {is_last, s_axis_tdata};
        end
    end

    // First-word-fall-through head; gated so stale storage never shows after reset.
    always_comb begin
        head          = mem[rd_ptr];
        m_axis_tvalid = (occ != '0);
        m_axis_tdata  = m_axis_tvalid ? head[B-1:0] : '0;
        m_axis_tlast  = m_axis_tvalid ? head[B] : 1'b0;
    end

endmodule

// File: tb/tb_axis_frame_buf_v1.sv
// Randomised scoreboard bench for axis_frame_buf_v1: a frame-level model predicts
// stored entries, a negedge monitor pops and compares every accepted output word.
module tb_axis_frame_buf_v1;

    localparam int unsigned B     = 256;
    localparam int unsigned AW    = 4;
    localparam int unsigned LW    = 16;
    localparam int          DEPTH = 16;

    logic          aclk          = 1'b0;
    logic          aresetn       = 1'b0;
    logic          s_axis_tvalid = 1'b0;
    logic [B-1:0]  s_axis_tdata  = '0;
    logic          m_axis_tvalid;
    logic          m_axis_tready = 1'b0;
    logic [B-1:0]  m_axis_tdata;
    logic          m_axis_tlast;
    logic          start_i       = 1'b0;
    logic [LW-1:0] len_i         = '0;
    logic          busy_o;
    logic          ovf_o;

    axis_frame_buf_v1 #(.B(B), .FIFO_AW(AW), .LEN_W(LW)) dut (
        .aclk          (aclk),
        .aresetn       (aresetn),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tdata  (s_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tlast  (m_axis_tlast),
        .start_i       (start_i),
        .len_i         (len_i),
        .busy_o        (busy_o),
        .ovf_o         (ovf_o)
    );

    always #5 aclk = ~aclk;

    int checks   = 0;
    int failures = 0;
    int out_words = 0;
    int out_lasts = 0;
    int rdy_mode  = 0;

    logic [B:0] sb [$];

    // Reference model state
    bit m_cap = 1'b0;
    bit m_ovf = 1'b0;
    int m_len = 0;
    int m_cnt = 0;
    int m_occ = 0;
    bit m_rd, m_wr, m_last;

    task automatic chk1(input string nm, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%b required=%b", nm, act, exp);
        end
    endtask

    task automatic chkw(input string nm, input logic [B:0] act, input logic [B:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic chki(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
        end
    endtask

    // Frame-level model: decides per accepted input word whether it is stored.
    always @(posedge aclk) begin
        if (!aresetn) begin
            sb.delete();
            m_cap = 1'b0;
            m_ovf = 1'b0;
            m_occ = 0;
            m_cnt = 0;
            m_len = 0;
        end else begin
            m_rd = (m_occ != 0) && m_axis_tready;
            m_wr = 1'b0;
            if (!m_cap) begin
                if (start_i && (len_i != '0)) begin
                    m_cap = 1'b1;
                    m_len = int'(len_i);
                    m_cnt = 0;
                    m_ovf = 1'b0;
                end
            end else if (s_axis_tvalid) begin
                m_last = (m_cnt == m_len - 1);
                if (m_occ < DEPTH - 1 || (m_last && (m_occ < DEPTH || m_rd))) begin
                    sb.push_back({m_last, s_axis_tdata});
                    m_wr = 1'b1;
                end else begin
                    m_ovf = 1'b1;
                end
                m_cnt++;
                if (m_last) m_cap = 1'b0;
            end
            m_occ = m_occ + int'(m_wr) - int'(m_rd);
        end
    end

    logic [B:0] prev_word  = '0;
    bit         prev_stall = 1'b0;
    logic [B:0] exp_word;

    // Monitor: pops on every handshake and checks flags and hold behaviour.
    always @(negedge aclk) begin
        if (!aresetn) begin
            prev_stall = 1'b0;
        end else begin
            chk1("tvalid", m_axis_tvalid, m_occ != 0);
            chk1("busy", busy_o, m_cap);
            chk1("ovf", ovf_o, m_ovf);
            if (prev_stall && m_axis_tvalid)
                chkw("hold", {m_axis_tlast, m_axis_tdata}, prev_word);
            if (m_axis_tvalid && m_axis_tready) begin
                if (sb.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL pop_empty actual=%0h required=nothing", {m_axis_tlast, m_axis_tdata});
                end else begin
                    exp_word = sb.pop_front();
                    chkw("word", {m_axis_tlast, m_axis_tdata}, exp_word);
                end
                out_words++;
                if (m_axis_tlast) out_lasts++;
            end
            prev_stall = m_axis_tvalid && !m_axis_tready;
            prev_word  = {m_axis_tlast, m_axis_tdata};
        end
    end

    always @(posedge aclk) begin
        #1;
        case (rdy_mode)
            0:       m_axis_tready = 1'b0;
            1:       m_axis_tready = 1'b1;
            default: m_axis_tready = ($urandom_range(3) != 0);
        endcase
    end

    function automatic logic [B-1:0] rnd();
        logic [B-1:0] r;
        for (int i = 0; i < int'(B / 32); i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    task automatic cyc();
        @(posedge aclk);
        #1;
    endtask

    task automatic start(input int len, input bit v);
        start_i       = 1'b1;
        len_i         = LW'(len);
        s_axis_tvalid = v;
        s_axis_tdata  = rnd();
        cyc();
        start_i       = 1'b0;
        s_axis_tvalid = 1'b0;
    endtask

    task automatic send(input int n, input int gap_pct);
        int sent = 0;
        while (sent < n) begin
            if (int'($urandom_range(99)) < gap_pct) begin
                s_axis_tvalid = 1'b0;
            end else begin
                s_axis_tvalid = 1'b1;
                s_axis_tdata  = rnd();
                sent++;
            end
            cyc();
        end
        s_axis_tvalid = 1'b0;
    endtask

    task automatic drain(input int budget);
        int t = 0;
        while ((m_occ != 0 || m_cap) && t < budget) begin
            cyc();
            t++;
        end
        if (t >= budget) begin
            checks++;
            failures++;
            $display("FAIL drain_timeout actual=%0d required=<%0d", t, budget);
        end
        repeat (3) cyc();
    endtask

    int w0, l0;

    initial begin
        // Reset state
        repeat (2) cyc();
        chk1("rst_tvalid", m_axis_tvalid, 1'b0);
        chk1("rst_tlast", m_axis_tlast, 1'b0);
        chk1("rst_busy", busy_o, 1'b0);
        chk1("rst_ovf", ovf_o, 1'b0);
        chkw("rst_tdata", {1'b0, m_axis_tdata}, '0);
        aresetn = 1'b1;
        cyc();

        // 1: simple frame of 4
        rdy_mode = 1;
        cyc();
        w0 = out_words; l0 = out_lasts;
        start(4, 1'b0);
        send(4, 0);
        drain(100);
        chki("t1_words", out_words - w0, 4);
        chki("t1_lasts", out_lasts - l0, 1);
        chk1("t1_ovf", ovf_o, 1'b0);

        // 2: zero length request is ignored
        w0 = out_words;
        start(0, 1'b0);
        repeat (5) cyc();
        chk1("t2_busy", busy_o, 1'b0);
        chki("t2_words", out_words - w0, 0);

        // 3: overflow with stalled DMA
        rdy_mode = 0;
        cyc();
        w0 = out_words; l0 = out_lasts;
        start(20, 1'b0);
        send(20, 0);
        cyc();
        chk1("t3_ovf", ovf_o, 1'b1);
        chk1("t3_tvalid", m_axis_tvalid, 1'b1);
        rdy_mode = 1;
        drain(200);
        chki("t3_words", out_words - w0, 16);
        chki("t3_lasts", out_lasts - l0, 1);

        // 4: words outside capture are discarded
        w0 = out_words;
        repeat (3) begin
            s_axis_tvalid = 1'b1;
            s_axis_tdata  = rnd();
            cyc();
        end
        start(3, 1'b1);
        send(3, 0);
        drain(100);
        chki("t4_words", out_words - w0, 3);

        // 5: reset mid-frame
        rdy_mode = 0;
        cyc();
        start(8, 1'b0);
        send(2, 0);
        chk1("t5_pre_tvalid", m_axis_tvalid, 1'b1);
        aresetn = 1'b0;
        #1;
        chk1("t5_tvalid", m_axis_tvalid, 1'b0);
        chk1("t5_tlast", m_axis_tlast, 1'b0);
        chk1("t5_busy", busy_o, 1'b0);
        chk1("t5_ovf", ovf_o, 1'b0);
        chkw("t5_tdata", {1'b0, m_axis_tdata}, '0);
        repeat (2) cyc();
        aresetn = 1'b1;
        rdy_mode = 1;
        cyc();
        w0 = out_words; l0 = out_lasts;
        start(3, 1'b0);
        send(3, 0);
        drain(100);
        chki("t5_words", out_words - w0, 3);
        chki("t5_lasts", out_lasts - l0, 1);

        // 6: long frame with random backpressure and input gaps
        rdy_mode = 2;
        w0 = out_words; l0 = out_lasts;
        start(100, 1'b0);
        send(100, 50);
        drain(2000);
        chki("t6_words", out_words - w0, 100);
        chki("t6_lasts", out_lasts - l0, 1);
        chk1("t6_ovf", ovf_o, 1'b0);

        // Back-to-back frames starting while the previous one drains
        w0 = out_words; l0 = out_lasts;
        begin
            int total = 0;
            for (int f = 0; f < 6; f++) begin
                int len = int'($urandom_range(1, 10));
                total += len;
                start(len, 1'b0);
                send(len, 30);
            end
            drain(2000);
            chki("bb_words", out_words - w0, total);
            chki("bb_lasts", out_lasts - l0, 6);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout actual=expired required=finish");
        $fatal(1, "timeout");
    end

endmodule
